// File: rtl/irrig_pkg.sv
// Shared types and default constants for the irrigation zone scheduler and its stepper driver.
package irrig_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_OPEN_REQ,
    S_OPEN_WAIT,
    S_DWELL,
    S_CLOSE_REQ,
    S_CLOSE_WAIT,
    S_ADVANCE
  } state_e;

  localparam logic DIR_OPEN  = 1'b0;
  localparam logic DIR_CLOSE = 1'b1;

  localparam int unsigned DEF_N_ZONES    = 5;
  localparam int unsigned DEF_TICK_DIV   = 50000;
  localparam int unsigned DEF_TIME_W     = 24;
  localparam int unsigned DEF_STEP_W     = 16;
  localparam int unsigned DEF_OPEN_STEPS = 512;
  localparam int unsigned DEF_DEFAULT_T  = 20000;

endpackage

// File: rtl/irrigation_zone_scheduler_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV cycles, restarted from zero by a sync clear.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Walks enabled zones in order through one shared valve actuator: open, dwell, close, advance.
module irrigation_zone_scheduler import irrig_pkg::*; #(
  parameter int unsigned N_ZONES    = DEF_N_ZONES,
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned TIME_W     = DEF_TIME_W,
  parameter int unsigned STEP_W     = DEF_STEP_W,
  parameter int unsigned OPEN_STEPS = DEF_OPEN_STEPS,
  parameter int unsigned DEFAULT_T  = DEF_DEFAULT_T,
  parameter int unsigned ZIDX_W     = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               cfg_we,
  input  logic [ZIDX_W-1:0]  cfg_zone,
  input  logic [TIME_W-1:0]  cfg_time,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_dir,
  output logic [STEP_W-1:0]  cmd_steps,
  input  logic               move_done,
  output logic [N_ZONES-1:0] zone_active,
  output logic [ZIDX_W-1:0]  cur_zone,
  output logic               busy,
  output logic               cycle_done
);

  localparam logic [ZIDX_W-1:0] LAST_Z = ZIDX_W'(N_ZONES - 1);
  localparam logic [ZIDX_W:0]   NZ     = (ZIDX_W + 1)'(N_ZONES);

  state_e              state_q, state_d;
  logic [ZIDX_W-1:0]   cur_zone_q, cur_zone_d;
  logic [N_ZONES-1:0]  za_q, za_d;
  logic [TIME_W-1:0]   dwell_q, dwell_d;
  logic [TIME_W-1:0]   times_q [N_ZONES];
  logic [TIME_W-1:0]   cur_time;
  logic                tick;
  logic                last_zone;
  logic                cfg_ok;

  assign cur_time  = times_q[cur_zone_q];
  assign last_zone = (cur_zone_q == LAST_Z);
  assign cfg_ok    = ({1'b0, cfg_zone} < NZ);

  // Divider runs only while dwelling, so each dwell starts on a fresh tick period.
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (clock),
    .rst_i  (reset),
    .clr_i  (state_q != S_DWELL),
    .tick_o (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (enable) state_d = S_SELECT;
      S_SELECT:     state_d = (cur_time == '0) ? S_ADVANCE : S_OPEN_REQ;
      S_OPEN_REQ: begin
        if (cmd_ready)    state_d = S_OPEN_WAIT;
        else if (!enable) state_d = S_IDLE;
      end
      S_OPEN_WAIT:  if (move_done) state_d = enable ? S_DWELL : S_CLOSE_REQ;
      S_DWELL: begin
        if (!enable || dwell_q == '0 || (tick && dwell_q == TIME_W'(1)))
          state_d = S_CLOSE_REQ;
      end
      S_CLOSE_REQ:  if (cmd_ready) state_d = S_CLOSE_WAIT;
      S_CLOSE_WAIT: if (move_done) state_d = S_ADVANCE;
      S_ADVANCE:    state_d = enable ? S_SELECT : S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid   = (state_q == S_OPEN_REQ) || (state_q == S_CLOSE_REQ);
    cmd_dir     = (state_q == S_CLOSE_REQ) ? DIR_CLOSE : DIR_OPEN;
    cmd_steps   = STEP_W'(OPEN_STEPS);
    busy        = (state_q != S_IDLE);
    cycle_done  = (state_q == S_ADVANCE) && last_zone;
    zone_active = za_q;
    cur_zone    = cur_zone_q;
  end

  always_comb begin
    cur_zone_d = cur_zone_q;
    za_d       = za_q;
    dwell_d    = dwell_q;
    case (state_q)
      S_IDLE:       if (enable) cur_zone_d = '0;
      S_OPEN_REQ:   if (cmd_ready) za_d = N_ZONES'(1) << cur_zone_q;
      // Dwell is latched here; later cfg writes only affect the next pass.
      S_OPEN_WAIT:  if (move_done) dwell_d = cur_time;
      S_DWELL:      if (tick && dwell_q != '0) dwell_d = dwell_q - TIME_W'(1);
      S_CLOSE_WAIT: if (move_done) za_d = '0;
      S_ADVANCE:    cur_zone_d = last_zone ? '0 : cur_zone_q + ZIDX_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_zone_q <= '0;
      za_q       <= '0;
      dwell_q    <= '0;
    end else begin
      cur_zone_q <= cur_zone_d;
      za_q       <= za_d;
      dwell_q    <= dwell_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N_ZONES); i++) times_q[i] <= TIME_W'(DEFAULT_T);
    end else if (cfg_we && cfg_ok) begin
      times_q[cfg_zone] <= cfg_time;
    end
  end

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Directed bench: scripted driver, event-level scoreboard model, literal pins on zone order and dwell lengths.
module tb_irrigation_zone_scheduler;

  localparam int NZ = 5, TD = 4, TW = 24, SW = 16, OS = 8, DT = 2, ZW = 3, DONE_DLY = 10;

  logic clock = 1'b0;
  logic reset, enable, cfg_we;
  logic [ZW-1:0] cfg_zone;
  logic [TW-1:0] cfg_time;
  logic cmd_valid, cmd_ready, cmd_dir, move_done;
  logic [SW-1:0] cmd_steps;
  logic [NZ-1:0] zone_active;
  logic [ZW-1:0] cur_zone;
  logic busy, cycle_done;

  int total = 0, bad = 0;
  int ack_dly = 2;

  always #5 clock = ~clock;

  irrigation_zone_scheduler #(
    .N_ZONES(NZ), .TICK_DIV(TD), .TIME_W(TW), .STEP_W(SW), .OPEN_STEPS(OS), .DEFAULT_T(DT)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .cfg_we(cfg_we), .cfg_zone(cfg_zone),
    .cfg_time(cfg_time), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .move_done(move_done), .zone_active(zone_active),
    .cur_zone(cur_zone), .busy(busy), .cycle_done(cycle_done)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stepper driver: raises ready ack_dly cycles into a request, pulses done DONE_DLY cycles after acceptance.
  initial begin
    int wait_c, done_c;
    bit pend;
    cmd_ready = 0; move_done = 0; pend = 0; wait_c = 0; done_c = 0;
    forever begin
      @(posedge clock); #1;
      move_done = 0;
      if (reset) begin
        cmd_ready = 0; pend = 0; wait_c = 0;
      end else if (cmd_ready) begin
        cmd_ready = 0; pend = 1; done_c = DONE_DLY; wait_c = 0;
      end else if (pend) begin
        done_c--;
        if (done_c == 0) begin move_done = 1; pend = 0; end
      end else if (cmd_valid) begin
        wait_c++;
        if (wait_c >= ack_dly) cmd_ready = 1;
      end else begin
        wait_c = 0;
      end
    end
  end

  // Scoreboard model state
  int cyc = 0;
  int m_times [NZ];
  int m_pos, m_open_z, done_cyc, dwell_exp, stall, gap;
  logic [NZ-1:0] m_za;
  bit m_out, m_out_dir, dwell_chk, wait_rise;
  logic p_valid, p_ready, p_dir, p_en;
  int open_log[$], close_log[$], dwell_log[$], stall_log[$];
  int cd_cnt = 0, valid_cnt = 0;

  function automatic int next_zone(input int from);
    for (int k = 0; k < NZ; k++)
      if (m_times[(from + k) % NZ] != 0) return (from + k) % NZ;
    return -1;
  endfunction

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      chk("rst_valid", cmd_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_za", zone_active, 0);
      chk("rst_zone", cur_zone, 0);
      chk("rst_cd", cycle_done, 0);
      chk("rst_dir", cmd_dir, 0);
      for (int i = 0; i < NZ; i++) m_times[i] = DT;
      m_pos = 0; m_za = '0; m_out = 0; dwell_chk = 0; wait_rise = 0; stall = 0;
      p_valid = 0; p_ready = 0; p_dir = 0; p_en = 0;
    end else begin
      chk("steps", cmd_steps, OS);
      chk("zone_active", zone_active, m_za);
      if (!busy) begin chk("idle_no_valid", cmd_valid, 0); m_pos = 0; end
      if (cmd_valid) begin chk("single_outstanding", m_out, 0); valid_cnt++; end
      if (cycle_done) begin cd_cnt++; chk("cd_last_zone", cur_zone, NZ - 1); end
      if (m_za != 0) chk("zone_held", cur_zone, m_open_z);
      if (p_valid && !p_ready && !(p_dir == 1'b0 && !p_en)) begin
        chk("hold_valid", cmd_valid, 1);
        chk("hold_dir", cmd_dir, p_dir);
      end
      if (wait_rise && !enable) dwell_chk = 0;
      if (cmd_valid && cmd_dir && !p_valid && wait_rise) begin
        wait_rise = 0;
        gap = cyc - done_cyc - 1;
        dwell_log.push_back(gap);
        if (dwell_chk) begin
          total++;
          if (gap < dwell_exp - 1 || gap > dwell_exp + 1) begin
            bad++;
            $display("FAIL dwell_len: got %0d expected %0d +/-1", gap, dwell_exp);
          end
        end
      end
      if (!cmd_valid) stall = 0;
      else if (!cmd_ready) stall++;
      if (cmd_valid && cmd_ready) begin
        if (!cmd_dir) begin
          chk("open_zone", cur_zone, next_zone(m_pos));
          chk("open_za_clear", zone_active, 0);
          open_log.push_back(int'(cur_zone));
          stall_log.push_back(stall);
          m_open_z = int'(cur_zone);
          m_za = NZ'(1) << cur_zone;
          m_pos = (int'(cur_zone) + 1) % NZ;
        end else begin
          chk("close_zone", cur_zone, m_open_z);
          chk("close_za_set", zone_active[m_open_z], 1);
          close_log.push_back(int'(cur_zone));
        end
        m_out = 1; m_out_dir = cmd_dir; stall = 0;
      end
      if (move_done && m_out) begin
        m_out = 0;
        if (!m_out_dir) begin
          done_cyc = cyc; dwell_exp = m_times[m_open_z] * TD;
          dwell_chk = enable; wait_rise = 1;
        end else begin
          m_za = '0;
        end
      end
      if (cfg_we && int'(cfg_zone) < NZ) m_times[cfg_zone] = int'(cfg_time);
      p_valid = cmd_valid; p_ready = cmd_ready; p_dir = cmd_dir; p_en = enable;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic cfg(input int z, input int t);
    cfg_we = 1; cfg_zone = ZW'(z); cfg_time = TW'(t);
    step(1);
    cfg_we = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 500) begin step(1); n++; end
    chk(nm, busy, 0);
  endtask

  task automatic wait_cd(input int tgt, input string nm);
    int n = 0;
    while (cd_cnt < tgt && n < 800) begin step(1); n++; end
    chk(nm, cd_cnt >= tgt, 1);
  endtask

  task automatic wait_dwells(input int tgt, input string nm);
    int n = 0;
    while (dwell_log.size() < tgt && n < 800) begin step(1); n++; end
    chk(nm, dwell_log.size() >= tgt, 1);
  endtask

  initial begin
    int ob, cb, db, sb, cdb, vb, n;
    bit hit;
    reset = 1; enable = 0; cfg_we = 0; cfg_zone = '0; cfg_time = '0;
    @(negedge clock);
    chk("t0_steps", cmd_steps, OS);
    chk("t0_busy", busy, 0);
    step(2);
    reset = 0;
    step(1);

    // Pass over {3,0,2,0,1}: zones 0,2,4 serviced with 12/8/4-cycle dwells
    cfg(0, 3); cfg(1, 0); cfg(2, 2); cfg(3, 0); cfg(4, 1);
    ob = open_log.size(); cb = close_log.size(); db = dwell_log.size(); cdb = cd_cnt;
    enable = 1;
    wait_cd(cdb + 1, "t1_cycle_done");
    chk("t1_opens", open_log.size() - ob, 3);
    chk("t1_open0", open_log[ob], 0);
    chk("t1_open1", open_log[ob + 1], 2);
    chk("t1_open2", open_log[ob + 2], 4);
    chk("t1_close2", close_log[cb + 2], 4);
    chk("t1_dwell0", dwell_log[db], 12);
    chk("t1_dwell1", dwell_log[db + 1], 8);
    chk("t1_dwell2", dwell_log[db + 2], 4);
    chk("t1_cd_once", cd_cnt - cdb, 1);
    wait_cd(cdb + 2, "t1_second_pass");
    chk("t1_opens2", open_log.size() - ob, 6);
    enable = 0;
    wait_idle("t1_idle");
    chk("t1_no_extra_open", open_log.size() - ob, 6);

    // Slow driver: 7 stalled cycles before acceptance
    ack_dly = 8;
    sb = stall_log.size(); cb = close_log.size();
    enable = 1;
    n = 0;
    while (stall_log.size() <= sb && n < 200) begin step(1); n++; end
    chk("t2_accepted", stall_log.size() > sb, 1);
    chk("t2_stall7", stall_log[sb], 7);
    enable = 0;
    wait_idle("t2_idle");
    chk("t2_closed", close_log.size() - cb, 1);
    chk("t2_za", zone_active, 0);

    // Enable drop mid-DWELL of zone 2
    ack_dly = 2;
    enable = 1;
    hit = 0; n = 0;
    while (!hit && n < 800) begin
      @(negedge clock); n++;
      hit = cmd_valid && cmd_ready && !cmd_dir && cur_zone == 3'd2;
    end
    chk("t3_open_z2", hit, 1);
    hit = 0; n = 0;
    while (!hit && n < 100) begin @(negedge clock); n++; hit = move_done; end
    chk("t3_open_done", hit, 1);
    step(4);
    enable = 0;
    @(negedge clock);
    chk("t3_still_dwell", cmd_valid, 0);
    @(negedge clock);
    chk("t3_close_req", cmd_valid, 1);
    chk("t3_close_dir", cmd_dir, 1);
    step(1);
    wait_idle("t3_idle");
    chk("t3_za_clear", zone_active, 0);
    chk("t3_zone_adv", cur_zone, 3);

    // Async reset during CLOSE_WAIT, then defaults (2 ticks = 8 cycles)
    enable = 1;
    hit = 0; n = 0;
    while (!hit && n < 800) begin
      @(negedge clock); n++;
      hit = cmd_valid && cmd_ready && cmd_dir;
    end
    chk("t4_close_acc", hit, 1);
    @(posedge clock); #3;
    reset = 1;
    #1;
    chk("t4_valid", cmd_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_za", zone_active, 0);
    chk("t4_zone", cur_zone, 0);
    chk("t4_cd", cycle_done, 0);
    chk("t4_dir", cmd_dir, 0);
    chk("t4_steps", cmd_steps, OS);
    step(2);
    reset = 0;
    db = dwell_log.size(); ob = open_log.size();
    wait_dwells(db + 1, "t4_dwell_seen");
    chk("t4_open_z0", open_log[ob], 0);
    chk("t4_default_dwell", dwell_log[db], 8);
    enable = 0;
    wait_idle("t4_idle");

    // All times zero: no commands, repeated cycle_done; out-of-range write ignored
    cfg(0, 0); cfg(1, 0); cfg(2, 0); cfg(3, 0); cfg(4, 0); cfg(6, 5);
    vb = valid_cnt; cdb = cd_cnt;
    enable = 1;
    step(60);
    chk("t5_no_valid", valid_cnt - vb, 0);
    chk("t5_cd_repeat", (cd_cnt - cdb >= 5) && (cd_cnt - cdb <= 6), 1);
    enable = 0;
    wait_idle("t5_idle");

    // Reprogram zone 0 during its dwell: 12 now, 20 next pass
    cfg(0, 3);
    db = dwell_log.size();
    enable = 1;
    hit = 0; n = 0;
    while (!hit && n < 200) begin @(negedge clock); n++; hit = move_done && zone_active[0]; end
    chk("t6_open_done", hit, 1);
    step(2);
    cfg(0, 5);
    wait_dwells(db + 2, "t6_two_dwells");
    chk("t6_dwell_now", dwell_log[db], 12);
    chk("t6_dwell_next", dwell_log[db + 1], 20);
    enable = 0;
    wait_idle("t6_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
